// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back and
// drives the datapath control word, with a memory-wait timeout and a retired count.
module multicycle_control_unit #(
  parameter int                  OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0] OP_NOP      = OPCODE_W'(0),
  parameter logic [OPCODE_W-1:0] OP_LOAD     = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0] OP_STORE    = OPCODE_W'(4),
  parameter logic [OPCODE_W-1:0] OP_BRZ      = OPCODE_W'(8),
  parameter logic [OPCODE_W-1:0] OP_HALT     = {OPCODE_W{1'b1}},
  parameter int                  MEM_TIMEOUT = 15,
  parameter int                  RETIRE_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic                  ir_write,
  input  logic                  zero_flag,
  input  logic                  mem_ready,
  output logic [OPCODE_W+4:0]   cw,
  output logic                  pc_write,
  output logic                  instr_done,
  output logic                  halted,
  output logic                  err,
  output logic [RETIRE_W-1:0]   retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_ERROR
  } state_t;

  state_t                state_r, state_s;
  logic [OPCODE_W-1:0]   op_r;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic [RETIRE_W-1:0]   retired_r;

  logic [OPCODE_W-1:0]   alu_op_s;
  logic alu_en_s, mem_read_s, mem_write_s, reg_write_s, pc_src_s;
  logic pc_write_s, done_s, ready_s, halted_s, err_s, accept_s;
  logic is_nop_s, is_load_s, is_store_s, is_brz_s, is_halt_s;

  assign is_nop_s   = (op_r == OP_NOP);
  assign is_load_s  = (op_r == OP_LOAD);
  assign is_store_s = (op_r == OP_STORE);
  assign is_brz_s   = (op_r == OP_BRZ);
  assign is_halt_s  = (op_r == OP_HALT);

  // State, captured opcode, memory wait counter and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      op_r      <= '0;
      wait_r    <= '0;
      retired_r <= '0;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
      if (accept_s) op_r <= opcode;
      if (done_s) retired_r <= retired_r + RETIRE_W'(1);
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_s     = state_r;
    wait_s      = wait_r;
    alu_op_s    = '0;
    alu_en_s    = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    pc_src_s    = 1'b0;
    pc_write_s  = 1'b0;
    done_s      = 1'b0;
    ready_s     = 1'b0;
    halted_s    = 1'b0;
    err_s       = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        ready_s  = 1'b1;
        accept_s = instr_valid;
        if (instr_valid) state_s = S_DECODE;
        else             state_s = S_FETCH;
      end
      S_DECODE: begin
        if (is_nop_s) begin
          pc_write_s = 1'b1;
          done_s     = 1'b1;
          state_s    = S_FETCH;
        end else if (is_halt_s) begin
          state_s = S_HALT;
        end else begin
          state_s = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_en_s = 1'b1;
        wait_s   = '0;
        if (is_load_s || is_store_s) begin
          state_s = S_MEM;
        end else if (is_brz_s) begin
          alu_op_s   = op_r;
          pc_src_s   = zero_flag;
          pc_write_s = 1'b1;
          done_s     = 1'b1;
          state_s    = S_FETCH;
        end else begin
          alu_op_s = op_r;
          state_s  = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_read_s  = is_load_s;
        mem_write_s = is_store_s;
        // A completing access wins over a timeout landing in the same cycle
        if (mem_ready) begin
          if (is_load_s) begin
            state_s = S_WRITEBACK;
          end else begin
            pc_write_s = 1'b1;
            done_s     = 1'b1;
            state_s    = S_FETCH;
          end
        end else begin
          if (wait_r != WAIT_MAX) wait_s = wait_r + WAIT_W'(1);
          else                    wait_s = wait_r;
          if ((MEM_TIMEOUT != 0) && (wait_r == WAIT_LAST)) state_s = S_ERROR;
          else                                             state_s = S_MEM;
        end
      end
      S_WRITEBACK: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        done_s      = 1'b1;
        state_s     = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
      end
      S_ERROR: begin
        halted_s = 1'b1;
        err_s    = 1'b1;
      end
      default: begin
        state_s = S_ERROR;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even though state sits in FETCH
  assign instr_ready = rst_n & ready_s;
  assign ir_write    = rst_n & ready_s & instr_valid;
  assign cw          = rst_n ? {pc_src_s, reg_write_s, mem_write_s, mem_read_s, alu_en_s, alu_op_s}
                             : '0;
  assign pc_write    = rst_n & pc_write_s;
  assign instr_done  = rst_n & done_s;
  assign halted      = rst_n & halted_s;
  assign err         = rst_n & err_s;
  assign retired     = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit; expectations come
// from a per-instruction cycle script derived from the instruction class.
module tb_multicycle_control_unit;

  localparam logic [5:0] ST_FET = 6'b100000;
  localparam logic [5:0] ST_DN  = 6'b001100;
  localparam logic [5:0] ST_HL  = 6'b000010;
  localparam logic [5:0] ST_ER  = 6'b000011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        instr_valid = 1'b0;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;

  logic        instr_ready, ir_write, pc_write, instr_done, halted, err;
  logic [8:0]  cw;
  logic [15:0] retired;

  logic        instr_ready_w, ir_write_w, pc_write_w, instr_done_w, halted_w, err_w;
  logic [8:0]  cw_w;
  logic [1:0]  retired_w;

  int checks = 0;
  int failures = 0;
  int model_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ir_write(ir_write), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .cw(cw), .pc_write(pc_write), .instr_done(instr_done),
    .halted(halted), .err(err), .retired(retired)
  );

  multicycle_control_unit #(.RETIRE_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready_w), .ir_write(ir_write_w), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .cw(cw_w), .pc_write(pc_write_w), .instr_done(instr_done_w),
    .halted(halted_w), .err(err_w), .retired(retired_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, compare at the falling edge, then advance past the rising edge
  task automatic step_cycle(input logic [8:0] ecw, input logic [5:0] est, input logic iv,
                            input logic mr);
    logic [5:0] exp_s;
    instr_valid = iv;
    mem_ready   = mr;
    @(negedge clk);
    exp_s    = est;
    exp_s[4] = est[5] & iv;
    check_eq("cw", 32'(cw), 32'(ecw));
    check_eq("status", 32'({instr_ready, ir_write, pc_write, instr_done, halted, err}), 32'(exp_s));
    check_eq("retired", 32'(retired), 32'(model_ret[15:0]));
    check_eq("cw_w", 32'(cw_w), 32'(ecw));
    check_eq("retired_w", 32'(retired_w), 32'(model_ret[1:0]));
    if (est[2]) model_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_valid = 1'b1;
    mem_ready   = 1'b1;
    rst_n       = 1'b0;
    #1;
    check_eq("rst_cw", 32'(cw), 32'd0);
    check_eq("rst_status", 32'({instr_ready, ir_write, pc_write, instr_done, halted, err}), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_retired_w", 32'(retired_w), 32'd0);
    model_ret = 0;
    @(negedge clk);
    check_eq("rst_hold_status", 32'({instr_ready, ir_write, halted, err}), 32'd0);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle behaviour of one instruction, from accept to completion
  task automatic run_instr(input logic [3:0] op, input int waits, input logic zf, input int idle);
    logic [8:0] mcw;
    zero_flag = zf;
    repeat (idle) step_cycle(9'h000, ST_FET, 1'b0, rb());
    opcode = op;
    step_cycle(9'h000, ST_FET, 1'b1, rb());
    opcode = 4'($urandom);
    if (op == 4'd0) begin
      step_cycle(9'h000, ST_DN, rb(), rb());
      return;
    end
    step_cycle(9'h000, 6'b000000, rb(), rb());
    if (op == 4'd15) begin
      repeat (3) step_cycle(9'h000, ST_HL, rb(), rb());
      return;
    end
    if (op == 4'd2 || op == 4'd4) begin
      step_cycle(9'h010, 6'b000000, rb(), rb());
      mcw = (op == 4'd2) ? 9'h020 : 9'h040;
      if (waits >= 15) begin
        repeat (15) step_cycle(mcw, 6'b000000, rb(), 1'b0);
        repeat (3) step_cycle(9'h000, ST_ER, rb(), rb());
        return;
      end
      repeat (waits) step_cycle(mcw, 6'b000000, rb(), 1'b0);
      if (op == 4'd2) begin
        step_cycle(mcw, 6'b000000, rb(), 1'b1);
        step_cycle(9'h080, ST_DN, rb(), rb());
      end else begin
        step_cycle(mcw, ST_DN, rb(), 1'b1);
      end
    end else if (op == 4'd8) begin
      step_cycle(9'h010 | 9'(op) | (zf ? 9'h100 : 9'h000), ST_DN, rb(), rb());
    end else begin
      step_cycle(9'h010 | 9'(op), 6'b000000, rb(), rb());
      step_cycle(9'h080, ST_DN, rb(), rb());
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    run_instr(4'd5, 0, 1'b1, 0);
    run_instr(4'd2, 2, 1'b0, 0);
    run_instr(4'd8, 0, 1'b1, 0);
    run_instr(4'd8, 0, 1'b0, 0);
    run_instr(4'd4, 0, 1'b0, 1);
    run_instr(4'd4, 3, 1'b1, 0);
    run_instr(4'd2, 14, 1'b0, 0);
    run_instr(4'd4, 14, 1'b0, 2);

    do_reset();
    repeat (5) run_instr(4'd0, 0, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      int sel;
      logic [3:0] op;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: op = 4'd0;
        1: op = 4'd2;
        2: op = 4'd4;
        3: op = 4'd8;
        default: begin
          op = 4'($urandom_range(1, 14));
          while (op == 4'd2 || op == 4'd4 || op == 4'd8) op = 4'($urandom_range(1, 14));
        end
      endcase
      run_instr(op, int'($urandom_range(0, 6)), rb(), int'($urandom_range(0, 2)));
    end

    run_instr(4'd4, 15, 1'b0, 0);
    do_reset();
    run_instr(4'd2, 20, 1'b0, 1);
    do_reset();
    run_instr(4'd7, 0, 1'b0, 0);
    run_instr(4'd15, 0, 1'b0, 0);
    do_reset();
    run_instr(4'd3, 0, 1'b0, 0);

    opcode = 4'd2;
    step_cycle(9'h000, ST_FET, 1'b1, 1'b0);
    step_cycle(9'h000, 6'b000000, 1'b0, 1'b0);
    step_cycle(9'h010, 6'b000000, 1'b0, 1'b0);
    step_cycle(9'h020, 6'b000000, 1'b0, 1'b0);
    do_reset();
    run_instr(4'd9, 0, 1'b0, 0);
    run_instr(4'd0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
